// File: rtl/gray_conv_scheduler.sv
// gray_conv_scheduler: four-requester round-robin front end for a shared
// binary<->Gray converter. One operation is in flight at a time.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_mode  : per-requester request valid / mode (0 b2g, 1 g2b)
//   req_data            : packed operands, requester k in [k*N +: N]
//   req_ready           : one-hot grant, only in IDLE
//   rsp_valid/rsp_ready : result handshake
//   rsp_id/mode/data    : owner, mode and converted value of the result
//   busy                : high whenever not IDLE
module gray_conv_scheduler #(
    parameter int unsigned N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req_valid,
    input  logic [3:0]       req_mode,
    input  logic [4*N-1:0]   req_data,
    output logic [3:0]       req_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_id,
    output logic             rsp_mode,
    output logic [N-1:0]     rsp_data,
    output logic             busy
);

    localparam int unsigned CW = (N > 2) ? $clog2(N - 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_RESP    = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   res_q, res_d;
    logic           mode_q, mode_d;
    logic [1:0]     id_q, id_d;

    logic           gnt_any;
    logic [1:0]     gnt_id;
    logic [1:0]     scan_idx;
    logic [N-1:0]   gnt_data;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and arbitration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            mode_q   <= 1'b0;
            id_q     <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            mode_q   <= mode_d;
            id_q     <= id_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        mode_d   = mode_q;
        id_d     = id_q;
        gnt_data = '0;
        for (int k = 0; k < 4; k++) begin
            if (2'(k) == gnt_id) begin
                gnt_data = req_data[k*N +: N];
            end
        end

        unique case (state_q)
            S_IDLE: begin
                // gnt_any implies the granted requester is valid: accept now.
                // res holds the raw operand; g2b resolves it in place.
                if (gnt_any) begin
                    res_d   = gnt_data;
                    mode_d  = req_mode[gnt_id];
                    id_d    = gnt_id;
                    cnt_d   = '0;
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (!mode_q) begin
                    res_d   = res_q ^ (res_q >> 1);
                    state_d = S_RESP;
                end else begin
                    // Bit N-2-cnt resolves against the already-resolved bit above it.
                    for (int i = 0; i < int'(N) - 1; i++) begin
                        if (CW'(int'(N) - 2 - i) == cnt_q) begin
                            res_d[i] = res_q[i] ^ res_q[i+1];
                        end
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 2)) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = 2'(id_q + 2'd1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: round-robin grant and result presentation
    always_comb begin
        req_ready = '0;
        gnt_any   = 1'b0;
        gnt_id    = rr_ptr_q;
        scan_idx  = '0;
        if (state_q == S_IDLE && rst_n) begin
            // Scan from farthest to nearest so the closest valid at/after rr_ptr wins.
            for (int k = 3; k >= 0; k--) begin
                scan_idx = 2'(rr_ptr_q + 2'(k));
                if (req_valid[scan_idx]) begin
                    gnt_any = 1'b1;
                    gnt_id  = scan_idx;
                end
            end
            if (gnt_any) begin
                req_ready[gnt_id] = 1'b1;
            end
        end
        busy      = (state_q != S_IDLE);
        rsp_valid = (state_q == S_RESP);
        rsp_id    = id_q;
        rsp_mode  = mode_q;
        rsp_data  = res_q;
    end

endmodule

// File: tb/tb_gray_conv_scheduler.sv
// Bench for gray_conv_scheduler (N=4): transaction-level model plus directed
// vectors with hand-computed results.
module tb_gray_conv_scheduler;

    localparam int unsigned N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     req_valid = '0;
    logic [3:0]     req_mode = '0;
    logic [4*N-1:0] req_data = '0;
    logic [3:0]     req_ready;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [1:0]     rsp_id;
    logic           rsp_mode;
    logic [N-1:0]   rsp_data;
    logic           busy;

    int total = 0;
    int bad   = 0;

    gray_conv_scheduler #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_mode  (req_mode),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_mode  (rsp_mode),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] b2g(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
        logic [N-1:0] b = '0;
        for (int s = 0; s < int'(N); s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic int pick(input logic [3:0] v, input int p);
        for (int i = 0; i < 4; i++) if (v[(p + i) % 4]) return (p + i) % 4;
        return -1;
    endfunction

    // ---------------- model ----------------
    int           m_phase = 0;   // 0 idle, 1 converting, 2 responding
    int           m_left  = 0;
    int           m_ptr   = 0;
    int           m_id    = 0;
    int           m_g     = 0;
    logic         m_mode  = 1'b0;
    logic [N-1:0] m_res   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_left = 0; m_ptr = 0; m_id = 0; m_mode = 1'b0; m_res = '0;
        end else begin
            case (m_phase)
                0: begin
                    m_g = pick(req_valid, m_ptr);
                    if (m_g >= 0) begin
                        m_id   = m_g;
                        m_mode = req_mode[m_g];
                        m_res  = m_mode ? g2b(req_data[m_g*N +: N]) : b2g(req_data[m_g*N +: N]);
                        m_left = m_mode ? int'(N) - 1 : 1;
                        m_phase = 1;
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: begin
                    if (rsp_ready) begin
                        m_phase = 0;
                        m_ptr   = (m_id + 1) % 4;
                    end
                end
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model
    logic [3:0] exp_rdy;
    int         exp_g;
    always @(negedge clk) begin
        exp_rdy = '0;
        exp_g   = pick(req_valid, m_ptr);
        if (m_phase == 0 && rst_n && exp_g >= 0) exp_rdy[exp_g] = 1'b1;
        chk("model_req_ready", req_ready, exp_rdy);
        chk("model_rsp_valid", rsp_valid, (m_phase == 2) ? 1 : 0);
        chk("model_busy", busy, (m_phase != 0) ? 1 : 0);
        if (m_phase == 2) begin
            chk("model_rsp_id", rsp_id, m_id);
            chk("model_rsp_mode", rsp_mode, m_mode);
            chk("model_rsp_data", rsp_data, m_res);
        end
    end

    // ---------------- directed ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_grant(input string name, input int k);
        int n = 0;
        @(negedge clk);
        while (req_ready == 4'd0 && n < 20) begin n++; @(negedge clk); end
        chk(name, req_ready, 32'(1) << k);
    endtask

    task automatic wait_rsp(input string name, input int id, input logic [N-1:0] exp);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin n++; @(negedge clk); end
        chk({name, "_valid"}, rsp_valid, 1);
        chk({name, "_id"}, rsp_id, id);
        chk({name, "_data"}, rsp_data, exp);
    endtask

    // Single request with exact latency check; operand and mode are
    // scrambled right after the accept to show they were latched.
    task automatic run_one(input int k, input logic m, input logic [N-1:0] d, input logic [N-1:0] exp);
        req_valid[k] = 1'b1; req_mode[k] = m; req_data[k*N +: N] = d; rsp_ready = 1'b1;
        wait_grant("one_grant", k);
        tick();
        req_valid[k] = 1'b0; req_data[k*N +: N] = ~d; req_mode[k] = ~m;
        for (int i = 0; i < (m ? 3 : 1); i++) begin
            @(negedge clk); chk("one_early", rsp_valid, 0); tick();
        end
        @(negedge clk);
        chk("one_valid", rsp_valid, 1);
        chk("one_data", rsp_data, exp);
        chk("one_id", rsp_id, k);
        chk("one_mode", rsp_mode, m);
        tick();
        @(negedge clk); chk("one_idle", busy, 0);
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0;
        tick();
        rst_n = 1'b1;
    endtask

    logic [N-1:0] rr_exp [4] = '{4'b0010, 4'b0110, 4'b1101, 4'b1000};
    int           order  [5] = '{0, 1, 2, 3, 0};

    initial begin
        #3;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_mode", rsp_mode, 0);
        tick();
        rst_n = 1'b1;

        // Single conversions, including the first edge after reset release
        run_one(0, 1'b0, 4'b1011, 4'b1110);
        run_one(2, 1'b1, 4'b1110, 4'b1011);
        run_one(2, 1'b1, 4'b0000, 4'b0000);
        run_one(3, 1'b0, 4'b1111, 4'b1000);

        // Round robin with all requesters held valid
        do_reset();
        req_mode = 4'b1010;
        req_data = {4'b1100, 4'b1001, 4'b0101, 4'b0011};
        req_valid = 4'b1111; rsp_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            wait_grant("rr_grant", order[g]);
            tick();
            wait_rsp("rr_rsp", order[g], rr_exp[order[g]]);
            tick();
        end
        req_valid = '0;

        // Response stall: outputs hold, no grants while waiting
        rsp_ready = 1'b0;
        req_valid[1] = 1'b1; req_mode[1] = 1'b0; req_data[1*N +: N] = 4'b0110;
        wait_grant("stall_grant", 1);
        tick();
        req_valid[1] = 1'b0;
        req_valid[3] = 1'b1; req_mode[3] = 1'b0; req_data[3*N +: N] = 4'b0000;
        wait_rsp("stall_rsp", 1, 4'b0101);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", rsp_valid, 1);
            chk("stall_data", rsp_data, 4'b0101);
            chk("stall_id", rsp_id, 1);
            chk("stall_ready", req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("stall_idle", busy, 0);
        chk("stall_next_grant", req_ready, 4'b1000);
        tick();
        req_valid[3] = 1'b0;
        wait_rsp("stall_r3", 3, 4'b0000);
        tick();

        // Reset in the middle of a Gray-to-binary conversion
        req_valid[1] = 1'b1; req_mode[1] = 1'b1; req_data[1*N +: N] = 4'b1110;
        wait_grant("abort_grant", 1);
        tick();
        req_valid[1] = 1'b0;
        req_valid[2] = 1'b1; req_mode[2] = 1'b0; req_data[2*N +: N] = 4'b0100;
        req_valid[3] = 1'b1; req_mode[3] = 1'b0; req_data[3*N +: N] = 4'b0001;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_req_ready", req_ready, 0);
        chk("abort_rsp_data", rsp_data, 0);
        chk("abort_rsp_id", rsp_id, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_regrant", req_ready, 4'b0100);
        tick();
        req_valid[2] = 1'b0;
        wait_rsp("abort_r2", 2, 4'b0110);
        tick();
        wait_grant("abort_grant3", 3);
        tick();
        req_valid[3] = 1'b0;
        wait_rsp("abort_r3", 3, 4'b0001);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/gray_conv_scheduler.md
GRAY_CONV_SCHEDULER -- requirements
Module: gray_conv_scheduler

Interface
REQ-001 SHALL have parameter: N, default 4, conversion data width (N >= 2).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req_valid  input  4  per-requester request valid.
REQ-005 SHALL have port: req_mode  input  4  per-requester mode: 0 = binary-to-Gray, 1 = Gray-to-binary.
REQ-006 SHALL have port: req_data  input  4*N  packed operands, requester k in bits [k*N +: N].
REQ-007 SHALL have port: req_ready  output  4  one-hot grant/accept strobe.
REQ-008 SHALL have port: rsp_valid  output  1  result valid.
REQ-009 SHALL have port: rsp_ready  input  1  consumer accepts result.
REQ-010 SHALL have port: rsp_id  output  2  index of the requester that owns the result.
REQ-011 SHALL have port: rsp_mode  output  1  mode of the result.
REQ-012 SHALL have port: rsp_data  output  N  converted value.
REQ-013 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, CONVERT and RESP; only one operation is in flight at a time.
REQ-015 In IDLE with any req_valid high, SHALL assert exactly one req_ready bit: the first valid requester at or after rr_ptr, scanning upward and wrapping 3->0; req_ready SHALL be 0 in all other states.
REQ-016 An accept occurs in cycle T when req_valid[k] and req_ready[k] are both high; the block SHALL then latch the operand, mode and id and enter CONVERT at T+1.
REQ-017 Binary-to-Gray SHALL occupy CONVERT for 1 cycle: gray[N-1] = b[N-1], gray[i] = b[i+1] ^ b[i].
REQ-018 Gray-to-binary SHALL occupy CONVERT for N-1 cycles, resolving one bit per cycle from MSB-1 down to bit 0: b[N-1] = g[N-1], b[i] = b[i+1] ^ g[i].
REQ-019 An iteration counter SHALL sequence the CONVERT cycles and SHALL reset to 0 on each accept.
REQ-020 SHALL enter RESP with rsp_valid high at T+2 for binary-to-Gray and at T+N for Gray-to-binary (T+4 when N=4).
REQ-021 In RESP, rsp_valid, rsp_id, rsp_mode and rsp_data SHALL hold stable until the cycle in which rsp_ready is high.
REQ-022 On the rsp_valid && rsp_ready cycle, SHALL return to IDLE next cycle and set rr_ptr = rsp_id + 1 (mod 4); no accept occurs in that same cycle.
REQ-023 Requests not granted SHALL be left pending; the block SHALL NOT drop, reorder or merge operands.
REQ-024 Under continuous requests from all four requesters, SHALL grant 0,1,2,3,0,... after reset; no requester waits more than 3 other grants.
REQ-025 rsp_ready high outside RESP SHALL be ignored.
REQ-026 Changes on req_mode or req_data after an accept SHALL NOT affect the in-flight result.

Reset
REQ-027 rst_n low SHALL immediately, independent of clk, force: state IDLE, rr_ptr 0, counter 0, req_ready 0, rsp_valid 0, rsp_id 0, rsp_mode 0, rsp_data 0, busy 0.
REQ-028 Reset asserted mid-CONVERT or mid-RESP SHALL abort the operation with no response; after release, the first grant follows REQ-015 with rr_ptr 0.
REQ-029 The first accept SHALL be possible in the first clock edge after rst_n deasserts.

Verification (N=4)
REQ-030 SHALL verify: req0 bin2gray 4'b1011, rsp_ready=1 -> rsp_valid at T+2, rsp_data 4'b1110, rsp_id 0.
REQ-031 SHALL verify: req2 gray2bin 4'b1110 -> rsp_valid at T+4, rsp_data 4'b1011, rsp_mode 1, rsp_id 2; also 4'b0000 -> 4'b0000 and bin2gray 4'b1111 -> 4'b1000.
REQ-032 SHALL verify: all four req_valid held high with distinct data -> grants in order 0,1,2,3,0, each result matching its own operand.
REQ-033 SHALL verify: rsp_ready held low for 5 cycles in RESP -> rsp_* stable, req_ready stays 0; rsp_ready=1 -> IDLE next cycle.
REQ-034 SHALL verify: rst_n pulsed low during gray2bin CONVERT -> outputs 0 asynchronously, no rsp_valid for that request, next grant goes to the lowest-index valid requester.
REQ-035 SHALL verify: req_data changed the cycle after accept -> result reflects the latched operand.
